// File: rtl/sc_pkg.sv
// Shared constants and types for the scoring-block metadata arbiter.
package sc_pkg;

  localparam int unsigned SC_N_REQ  = 37;
  localparam int unsigned SC_DATA_W = 16;
  localparam int unsigned SC_PTR_W  = 8;
  localparam int unsigned SC_IDX_W  = 6;
  localparam int unsigned SC_RD_LAT = 2;

  // One entry of the read-tag pipeline that travels alongside mem_en.
  typedef struct packed {
    logic                valid;
    logic [SC_IDX_W-1:0] idx;
    logic                last;   // read was for the final entry of the lane
  } sc_tag_t;

  // Low bit of requester idx's slot inside the flattened link bus.
  function automatic int unsigned sc_slot_lo(int unsigned idx, int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/sc_rr_pick.sv
// Round-robin picker: first eligible index strictly after last_grant, wrapping modulo N_REQ.
module sc_rr_pick
  import sc_pkg::*;
#(
  parameter int unsigned N_REQ = SC_N_REQ,
  parameter int unsigned IDX_W = SC_IDX_W
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  logic             hi_any;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Two passes in one loop: lowest eligible above last_grant, else lowest eligible overall.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    any    = 1'b0;
    lo_idx = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        any    = 1'b1;
        lo_idx = IDX_W'(i);
        if (i > int'(last_grant)) begin
          hi_any = 1'b1;
          hi_idx = IDX_W'(i);
        end
      end
    end
    winner = hi_any ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/sc_metadata_arbiter.sv
// Shares the single-port note-metadata RAM among the note matchers: one round-robin read per
// cycle, per-requester lane pointers, and a tag pipeline that steers returned words to slots.
module sc_metadata_arbiter
  import sc_pkg::*;
#(
  parameter int unsigned N_REQ  = SC_N_REQ,
  parameter int unsigned DATA_W = SC_DATA_W,
  parameter int unsigned PTR_W  = SC_PTR_W,
  parameter int unsigned RD_LAT = SC_RD_LAT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pause,
  input  logic                      rewind,
  input  logic [N_REQ-1:0]          metadata_request,
  output logic [N_REQ-1:0]          metadata_available,
  output logic [N_REQ*DATA_W-1:0]   metadata_link,
  output logic [N_REQ-1:0]          lane_exhausted,
  output logic                      mem_en,
  output logic [SC_IDX_W+PTR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned       IDX_W    = SC_IDX_W;
  localparam logic [PTR_W-1:0] PTR_LAST = '1;

  logic [PTR_W-1:0]       ptr_q [N_REQ];
  logic [DATA_W-1:0]      link_q [N_REQ];
  logic [N_REQ-1:0]       pending_q;
  logic [N_REQ-1:0]       available_q;
  logic [N_REQ-1:0]       exhausted_q;
  logic [IDX_W-1:0]       last_grant_q;
  logic                   mem_en_q;
  logic [IDX_W+PTR_W-1:0] mem_addr_q;
  sc_tag_t                tag_q [RD_LAT];

  logic [N_REQ-1:0] eligible;
  logic [IDX_W-1:0] winner;
  logic             pick_any;
  logic             grant;
  logic [PTR_W-1:0] win_ptr;
  sc_tag_t          new_tag;
  sc_tag_t          cap;

  assign eligible = metadata_request & ~available_q & ~pending_q & ~exhausted_q;

  sc_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any        (pick_any)
  );

  // rewind outranks pause; either one blocks new grants.
  assign grant   = pick_any & ~pause & ~rewind;
  assign win_ptr = ptr_q[winner];
  assign cap     = tag_q[RD_LAT-1];

  // Tag entering the pipeline this cycle.
  always_comb begin
    new_tag       = '0;
    new_tag.valid = grant;
    new_tag.idx   = winner;
    new_tag.last  = (win_ptr == PTR_LAST);
  end

  // Grant issue, tag shift, capture, handshake clear; rewind overrides the lane state last.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        ptr_q[i]  <= '0;
        link_q[i] <= '0;
      end
      for (int s = 0; s < int'(RD_LAT); s++) begin
        tag_q[s] <= '0;
      end
      pending_q    <= '0;
      available_q  <= '0;
      exhausted_q  <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      mem_en_q <= grant;
      tag_q[0] <= new_tag;
      for (int s = 1; s < int'(RD_LAT); s++) begin
        tag_q[s] <= tag_q[s-1];
      end
      available_q <= available_q & metadata_request;
      if (grant) begin
        mem_addr_q        <= {winner, win_ptr};
        last_grant_q      <= winner;
        pending_q[winner] <= 1'b1;
        ptr_q[winner]     <= win_ptr + PTR_W'(1);
      end
      // A dropped request still consumes the entry, it just never shows as available.
      if (cap.valid) begin
        link_q[cap.idx]      <= mem_rdata;
        pending_q[cap.idx]   <= 1'b0;
        available_q[cap.idx] <= metadata_request[cap.idx];
        if (cap.last) begin
          exhausted_q[cap.idx] <= 1'b1;
        end
      end
      // Song restart: link keeps stale data, last_grant keeps its rotation.
      if (rewind) begin
        for (int i = 0; i < int'(N_REQ); i++) begin
          ptr_q[i] <= '0;
        end
        for (int s = 0; s < int'(RD_LAT); s++) begin
          tag_q[s] <= '0;
        end
        pending_q   <= '0;
        available_q <= '0;
        exhausted_q <= '0;
      end
    end
  end

  // Flatten the per-requester link registers onto the output bus.
  always_comb begin
    metadata_link = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      metadata_link[sc_slot_lo(i, DATA_W) +: DATA_W] = link_q[i];
    end
  end

  assign metadata_available = available_q;
  assign lane_exhausted     = exhausted_q;
  assign mem_en             = mem_en_q;
  assign mem_addr           = mem_addr_q;

endmodule
